instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Instruction-cycle controller for the 8-bit accumulator CPU. Runs a fixed
//  8-state fetch/execute cycle per instruction and drives the single-cycle
//  strobes for PC, IR, accumulator, memory, the data-bus driver and the ALU
//  clock enable. Sits between the IR opcode field and the datapath. Also
//  counts retired instructions and latches HLT.
// PARAMETERS
//  CNT_W  16  width of retired-instruction counter instr_cnt
// PORTS
//  clk          in   1      system clock; everything samples on posedge
//  reset        in   1      synchronous, active-low reset
//  ena          in   1      run enable; sampled only in IDLE and at end of E7
//  opcode       in   3      IR[7:5]; HLT=000 SKZ=001 ADD=010 ANDD=011 XORR=100 LDA=101 STO=110 JMP=111
//  zero         in   1      ALU zero flag (accum==0)
//  inc_pc       out  1      PC increment strobe
//  load_pc      out  1      PC load from IR address
//  load_ir      out  1      IR byte load
//  load_acc     out  1      accumulator load from alu_out
//  rd           out  1      memory read
//  wr           out  1      memory write
//  datactl_ena  out  1      drive alu_out onto data bus
//  alu_en       out  1      ALU clock enable (one E4 pulse per instruction)
//  halt         out  1      CPU halted
//  retire       out  1      1-cycle pulse in E7 of each completed instruction
//  instr_cnt    out  CNT_W  retired-instruction count
//  state        out  4      current state (debug)
// BEHAVIOUR
//  States: IDLE=0 F0=1 F1=2 F2=3 E3=4 E4=5 E5=6 E6=7 E7=8 HALT=9.
//  - Reset (reset==0 at posedge): state=IDLE, op_q=0, zero_q=0,
//    instr_cnt=0. Applies in any state, including mid-instruction or HALT.
//  - All strobes are combinational decode of (state, op_q, zero_q) and are
//    0 whenever state is IDLE. One register stage only, with no extra latency.
//  - IDLE: go to F0 if ena, else stay in IDLE.
//  - Sequence: F0->F1->F2->E3->E4->E5->E6->E7.
//  - After E7: go to F0 if ena, else IDLE. Deasserting ena mid-instruction
//    never aborts the instruction.
//  - op_q captures opcode at the end of F2. zero_q captures zero at the end of E4.
//  Strobe table (any strobe not listed is 0):
//  - F0: rd, load_ir.
//  - F1: rd, load_ir, inc_pc.
//  - F2: none.
//  - E3: inc_pc, unless op_q==HLT. If op_q==HLT: halt=1 and next state = HALT.
//  - E4: alu_en for all non-HLT ops. Plus, by op_q:
//    ADD/ANDD/XORR/LDA: rd. JMP: load_pc. STO: datactl_ena.
//  - E5: ADD/ANDD/XORR/LDA: rd, load_acc. STO: wr, datactl_ena.
//    JMP: load_pc, inc_pc. SKZ: inc_pc if zero_q.
//  - E6: ADD/ANDD/XORR/LDA: rd. STO: datactl_ena.
//  - E7: retire=1. SKZ: inc_pc if zero_q.
//  - HALT: halt=1, all other strobes 0. ena ignored; exited only by reset.
//    retire is not asserted for HLT, and instr_cnt does not count HLT.
//  - instr_cnt increments at the end of E7 and saturates at 2^CNT_W-1.
//  - wr and rd are never high together. load_pc and inc_pc are high
//    together only in JMP E5, where the PC gives load priority.
// TESTING
//  1 Reset low 2 cycles, then high, ena=0 for 5 cycles
//    -> state=0 throughout, all outputs 0, instr_cnt=0.
//  2 ena=1, opcode=ADD
//    -> rd+load_ir in F0,F1; alu_en+rd in E4; load_acc in E5 only;
//       retire in E7; instr_cnt=1; state=F0 on the next cycle.
//  3 SKZ with zero=1 at E4 -> inc_pc high in F1,E3,E5,E7 (4 pulses).
//    SKZ with zero=0 -> inc_pc high in F1,E3 only.
//  4 STO -> datactl_ena high in E4..E6, wr high in E5 only, rd never high
//    in E3..E7. JMP -> load_pc high in E4,E5.
//  5 HLT -> halt=1 from E3 on, state=9 held 20 cycles with ena=1,
//    instr_cnt unchanged. Then reset low 1 cycle -> IDLE, halt=0.
//  6 ADD with ena dropped in E4 -> completes through E7, then IDLE.
//    Second ADD with reset low in E5 -> next cycle all outputs 0,
//    state=0, instr_cnt=0.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Control/strobe bundle between the instruction sequencer and the CPU datapath.
// The slave modport is the sequencer side; master is the datapath/IR side.
interface instr_sequencer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             ena;
  logic [2:0]       opcode;
  logic             zero;
  logic             inc_pc;
  logic             load_pc;
  logic             load_ir;
  logic             load_acc;
  logic             rd;
  logic             wr;
  logic             datactl_ena;
  logic             alu_en;
  logic             halt;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;
  logic [3:0]       state;

  modport master (
    output ena, opcode, zero,
    input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena,
           alu_en, halt, retire, instr_cnt, state
  );

  modport slave (
    input  ena, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena,
           alu_en, halt, retire, instr_cnt, state
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fixed 8-state fetch/execute controller for the 8-bit accumulator CPU.
// Strobes decode the registered state/opcode/zero; also counts retired instructions.
module instr_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_E3   = 4'd4,
    S_E4   = 4'd5,
    S_E5   = 4'd6,
    S_E6   = 4'd7,
    S_E7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic inc_pc_c, load_pc_c, load_ir_c, load_acc_c, rd_c, wr_c;
  logic datactl_ena_c, alu_en_c, halt_c, retire_c;
  logic mem_op_c, is_sto_c, is_jmp_c, is_skz_c;

  // Operand-fetching ops read memory in E4..E6 and load the accumulator in E5.
  assign mem_op_c = (op_q == OP_ADD) || (op_q == OP_ANDD) ||
                    (op_q == OP_XORR) || (op_q == OP_LDA);
  assign is_sto_c = (op_q == OP_STO);
  assign is_jmp_c = (op_q == OP_JMP);
  assign is_skz_c = (op_q == OP_SKZ);

  // Next-state and strobe decode
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    zero_d        = zero_q;
    cnt_d         = cnt_q;
    inc_pc_c      = 1'b0;
    load_pc_c     = 1'b0;
    load_ir_c     = 1'b0;
    load_acc_c    = 1'b0;
    rd_c          = 1'b0;
    wr_c          = 1'b0;
    datactl_ena_c = 1'b0;
    alu_en_c      = 1'b0;
    halt_c        = 1'b0;
    retire_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ena) state_d = S_F0;
      end
      S_F0: begin
        rd_c      = 1'b1;
        load_ir_c = 1'b1;
        state_d   = S_F1;
      end
      S_F1: begin
        rd_c      = 1'b1;
        load_ir_c = 1'b1;
        inc_pc_c  = 1'b1;
        state_d   = S_F2;
      end
      S_F2: begin
        op_d    = bus.opcode;
        state_d = S_E3;
      end
      S_E3: begin
        if (op_q == OP_HLT) begin
          halt_c  = 1'b1;
          state_d = S_HALT;
        end else begin
          inc_pc_c = 1'b1;
          state_d  = S_E4;
        end
      end
      S_E4: begin
        alu_en_c      = 1'b1;
        rd_c          = mem_op_c;
        load_pc_c     = is_jmp_c;
        datactl_ena_c = is_sto_c;
        zero_d        = bus.zero;
        state_d       = S_E5;
      end
      S_E5: begin
        rd_c          = mem_op_c;
        load_acc_c    = mem_op_c;
        wr_c          = is_sto_c;
        datactl_ena_c = is_sto_c;
        load_pc_c     = is_jmp_c;
        inc_pc_c      = is_jmp_c || (is_skz_c && zero_q);
        state_d       = S_E6;
      end
      S_E6: begin
        rd_c          = mem_op_c;
        datactl_ena_c = is_sto_c;
        state_d       = S_E7;
      end
      S_E7: begin
        retire_c = 1'b1;
        inc_pc_c = is_skz_c && zero_q;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        state_d  = bus.ena ? S_F0 : S_IDLE;
      end
      S_HALT: begin
        halt_c = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.inc_pc      = inc_pc_c;
  assign bus.load_pc     = load_pc_c;
  assign bus.load_ir     = load_ir_c;
  assign bus.load_acc    = load_acc_c;
  assign bus.rd          = rd_c;
  assign bus.wr          = wr_c;
  assign bus.datactl_ena = datactl_ena_c;
  assign bus.alu_en      = alu_en_c;
  assign bus.halt        = halt_c;
  assign bus.retire      = retire_c;
  assign bus.instr_cnt   = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_instr_sequencer;

  localparam int unsigned CNT_W = 16;

  // Strobe vector bit positions: {inc_pc,load_pc,load_ir,load_acc,rd,wr,datactl_ena,alu_en,halt,retire}
  localparam logic [9:0] INC  = 10'h200;
  localparam logic [9:0] LPC  = 10'h100;
  localparam logic [9:0] LIR  = 10'h080;
  localparam logic [9:0] LACC = 10'h040;
  localparam logic [9:0] RD   = 10'h020;
  localparam logic [9:0] WR   = 10'h010;
  localparam logic [9:0] DCTL = 10'h008;
  localparam logic [9:0] ALU  = 10'h004;
  localparam logic [9:0] HLT  = 10'h002;
  localparam logic [9:0] RET  = 10'h001;
  localparam logic [9:0] NONE = 10'h000;

  typedef struct packed {
    logic [3:0]       st;
    logic [9:0]       v;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  // Hand-written expected strobes for F0,F1,F2,E3,E4,E5,E6,E7
  logic [9:0] t_mem  [8] = '{RD|LIR, RD|LIR|INC, NONE, INC, ALU|RD,   RD|LACC, RD,   RET};
  logic [9:0] t_skz1 [8] = '{RD|LIR, RD|LIR|INC, NONE, INC, ALU,      INC,     NONE, RET|INC};
  logic [9:0] t_skz0 [8] = '{RD|LIR, RD|LIR|INC, NONE, INC, ALU,      NONE,    NONE, RET};
  logic [9:0] t_sto  [8] = '{RD|LIR, RD|LIR|INC, NONE, INC, ALU|DCTL, WR|DCTL, DCTL, RET};
  logic [9:0] t_jmp  [8] = '{RD|LIR, RD|LIR|INC, NONE, INC, ALU|LPC,  LPC|INC, NONE, RET};
  logic [9:0] t_hlt  [8] = '{RD|LIR, RD|LIR|INC, NONE, HLT, HLT,      HLT,     HLT,  HLT};

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_sequencer_if #(.CNT_W(CNT_W)) bus ();

  instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t             q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic logic [9:0] exp_vec(input logic [2:0] op, input logic z, input int s);
    case (op)
      3'b000:  return t_hlt[s];
      3'b001:  return z ? t_skz1[s] : t_skz0[s];
      3'b110:  return t_sto[s];
      3'b111:  return t_jmp[s];
      default: return t_mem[s];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [3:0] st, input logic [9:0] v, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.st  = st;
    e.v   = v;
    e.cnt = cnt;
    q.push_back(e);
  endtask

  // One instruction; optionally drop ena or pulse reset after a given step (-1 = never).
  task automatic run_instr(input logic [2:0] op, input logic z, input int drop_at, input int rst_at);
    bus.opcode = op;
    bus.zero   = z;
    for (int s = 0; s < 8; s++) begin
      tick();
      push(4'(s + 1), exp_vec(op, z, s), exp_cnt);
      if (s == drop_at) bus.ena = 1'b0;
      if (s == rst_at) begin
        reset   = 1'b0;
        bus.ena = 1'b0;
        tick();
        exp_cnt = '0;
        push(4'd0, NONE, exp_cnt);
        reset = 1'b1;
        return;
      end
    end
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t       e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {bus.inc_pc, bus.load_pc, bus.load_ir, bus.load_acc, bus.rd, bus.wr,
             bus.datactl_ena, bus.alu_en, bus.halt, bus.retire};
      checks++;
      if (bus.state !== e.st || act !== e.v || bus.instr_cnt !== e.cnt) begin
        errors++;
        $display("FAIL cycle_chk%0d @%0t: got state=%0d strobes=%b cnt=%0d, required state=%0d strobes=%b cnt=%0d",
                 checks, $time, bus.state, act, bus.instr_cnt, e.st, e.v, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.ena    = 1'b0;
    bus.opcode = 3'b000;
    bus.zero   = 1'b0;
    reset      = 1'b0;

    // Reset held 2 cycles, then idle with ena low
    repeat (2) begin
      tick();
      push(4'd0, NONE, exp_cnt);
    end
    reset = 1'b1;
    repeat (5) begin
      tick();
      push(4'd0, NONE, exp_cnt);
    end

    // Back-to-back instructions
    bus.ena = 1'b1;
    run_instr(3'b010, 1'b0, -1, -1);  // ADD
    run_instr(3'b001, 1'b1, -1, -1);  // SKZ taken
    run_instr(3'b001, 1'b0, -1, -1);  // SKZ not taken
    run_instr(3'b110, 1'b0, -1, -1);  // STO
    run_instr(3'b111, 1'b0, -1, -1);  // JMP
    run_instr(3'b101, 1'b1, -1, -1);  // LDA
    run_instr(3'b011, 1'b0, -1, -1);  // ANDD
    run_instr(3'b100, 1'b1, -1, -1);  // XORR
    run_instr(3'b010, 1'b0, 4, -1);   // ADD, ena dropped in E4
    repeat (2) begin
      tick();
      push(4'd0, NONE, exp_cnt);
    end

    // HLT: halt from E3, then parked in HALT regardless of ena
    bus.ena    = 1'b1;
    bus.opcode = 3'b000;
    for (int s = 0; s < 4; s++) begin
      tick();
      push(4'(s + 1), exp_vec(3'b000, 1'b0, s), exp_cnt);
    end
    repeat (20) begin
      tick();
      push(4'd9, HLT, exp_cnt);
    end
    reset   = 1'b0;
    bus.ena = 1'b0;
    tick();
    exp_cnt = '0;
    push(4'd0, NONE, exp_cnt);
    reset = 1'b1;
    tick();
    push(4'd0, NONE, exp_cnt);

    // ADD retiring once, then a second ADD aborted by reset in E5
    bus.ena = 1'b1;
    run_instr(3'b010, 1'b0, -1, -1);
    run_instr(3'b010, 1'b0, -1, 5);
    tick();
    push(4'd0, NONE, exp_cnt);

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
